// File: rtl/picomips_seq_ctrl.sv
// picoMips instruction sequencer: program counter, four-phase cycle, SW8 (HEI)
// handshake with synchroniser/debounce, and single-step debug mode.
module picomips_seq_ctrl #(
  parameter int PC_W     = 5,
  parameter int PROG_LEN = 24,
  parameter int DEBOUNCE = 4
) (
  input  logic            Clock,
  input  logic            nReset,
  input  logic [2:0]      Func,
  input  logic            HeiArg,
  input  logic            Sw8,
  input  logic            StepEn,
  input  logic            StepReq,
  output logic [PC_W-1:0] Pc,
  output logic [1:0]      Phase,
  output logic            AccWE,
  output logic            RegWE,
  output logic            Waiting,
  output logic            Stepping
);

  localparam logic [2:0] OP_ATR = 3'b101;
  localparam logic [2:0] OP_HEI = 3'b111;

  localparam int DB_N  = (DEBOUNCE < 1) ? 1 : DEBOUNCE;
  localparam int CNT_W = (DB_N > 1) ? $clog2(DB_N) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_N - 1);
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(PROG_LEN - 1);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXEC      = 3'd2,
    WB        = 3'd3,
    WAIT_HEI  = 3'd4,
    STEP_WAIT = 3'd5
  } state_t;

  state_t            state, state_next;
  logic [PC_W-1:0]   pc_q;
  logic              pc_adv;
  logic              acc_we_q, reg_we_q;
  logic              sw8_m, sw8_s, sw8_db;
  logic [CNT_W-1:0]  db_cnt;
  logic              step_prev;
  logic              step_rise;

  // SW8 conditioning: two-flop synchroniser then a run-length debounce
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sw8_m  <= 1'b0;
      sw8_s  <= 1'b0;
      sw8_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      sw8_m <= Sw8;
      sw8_s <= sw8_m;
      if (sw8_s == sw8_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        sw8_db <= sw8_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) step_prev <= 1'b0;
    else         step_prev <= StepReq;
  end

  assign step_rise = StepReq & ~step_prev;

  always_comb begin
    state_next = state;
    pc_adv     = 1'b0;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC:   state_next = WB;
      WB: begin
        if (Func == OP_HEI && sw8_db == HeiArg) begin
          state_next = WAIT_HEI;
        end else if (StepEn) begin
          state_next = STEP_WAIT;
        end else begin
          state_next = FETCH;
          pc_adv     = 1'b1;
        end
      end
      WAIT_HEI: begin
        if (sw8_db != HeiArg) begin
          pc_adv     = 1'b1;
          state_next = StepEn ? STEP_WAIT : FETCH;
        end
      end
      STEP_WAIT: begin
        if (step_rise || !StepEn) begin
          pc_adv     = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // Enables are loaded on the EXEC->WB edge so they are high for exactly the WB cycle
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state    <= FETCH;
      pc_q     <= '0;
      acc_we_q <= 1'b0;
      reg_we_q <= 1'b0;
    end else begin
      state    <= state_next;
      acc_we_q <= (state_next == WB) && (Func != OP_HEI) && (Func != OP_ATR);
      reg_we_q <= (state_next == WB) && (Func == OP_ATR);
      if (pc_adv) pc_q <= (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;
    end
  end

  always_comb begin
    Pc       = pc_q;
    Phase    = (state == WAIT_HEI || state == STEP_WAIT) ? 2'd3 : state[1:0];
    AccWE    = acc_we_q;
    RegWE    = reg_we_q;
    Waiting  = (state == WAIT_HEI);
    Stepping = (state == STEP_WAIT);
  end

endmodule

// File: tb/tb_picomips_seq_ctrl.sv
// Self-checking bench for picomips_seq_ctrl: per-instruction WB scoreboard plus
// directed checks of phase timing, HEI hold/debounce, wrap, step mode and reset.
module tb_picomips_seq_ctrl;

  localparam int PC_W     = 5;
  localparam int PROG_LEN = 24;
  localparam int DEBOUNCE = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ATR = 3'b101;
  localparam logic [2:0] OP_HEI = 3'b111;

  logic            Clock = 1'b0;
  logic            nReset = 1'b0;
  logic [2:0]      Func = OP_ADD;
  logic            HeiArg = 1'b0;
  logic            Sw8 = 1'b0;
  logic            StepEn = 1'b0;
  logic            StepReq = 1'b0;
  logic [PC_W-1:0] Pc;
  logic [1:0]      Phase;
  logic            AccWE, RegWE, Waiting, Stepping;

  typedef struct {
    int pc;
    int acc;
    int rg;
  } exp_t;

  exp_t sb[$];
  int   model_pc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  picomips_seq_ctrl #(
    .PC_W    (PC_W),
    .PROG_LEN(PROG_LEN),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .Clock   (Clock),
    .nReset  (nReset),
    .Func    (Func),
    .HeiArg  (HeiArg),
    .Sw8     (Sw8),
    .StepEn  (StepEn),
    .StepReq (StepReq),
    .Pc      (Pc),
    .Phase   (Phase),
    .AccWE   (AccWE),
    .RegWE   (RegWE),
    .Waiting (Waiting),
    .Stepping(Stepping)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int pc_inc(input int p);
    return (p == PROG_LEN - 1) ? 0 : p + 1;
  endfunction

  // Push the expected WB outcome when an instruction is fetched; pop it at WB.
  always @(negedge Clock) begin
    exp_t e;
    if (!nReset) begin
      sb.delete();
      model_pc = 0;
    end else begin
      if (Phase == 2'd0) begin
        e.pc  = model_pc;
        e.acc = (Func != OP_HEI && Func != OP_ATR) ? 1 : 0;
        e.rg  = (Func == OP_ATR) ? 1 : 0;
        sb.push_back(e);
        model_pc = pc_inc(model_pc);
      end
      if (Phase == 2'd3 && !Waiting && !Stepping) begin
        if (sb.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_wb_pc", Pc, e.pc);
          check_eq("sb_wb_accwe", AccWE, e.acc);
          check_eq("sb_wb_regwe", RegWE, e.rg);
        end
      end
    end
  end

  task automatic reset_dut();
    nReset = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #2 nReset = 1'b1;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    do begin
      @(posedge Clock);
      #2;
      n++;
    end while (Phase != 2'd0 && n < 200);
    check_eq("fetch_reached", (n < 200) ? 1 : 0, 1);
  endtask

  task automatic run_instr(input logic [2:0] f, input logic a,
                           output int pc_o, output int acc_n,
                           output int reg_n, output int wait_n);
    wait_fetch();
    pc_o   = Pc;
    Func   = f;
    HeiArg = a;
    acc_n  = 0;
    reg_n  = 0;
    wait_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      acc_n  += AccWE;
      reg_n  += RegWE;
      wait_n += Waiting;
    end
  endtask

  initial begin
    int p, p_hei, hold, acc_n, reg_n, wait_n, cnt;

    // Free-running ADD sequence, phase timing and PC wrap
    Func = OP_ADD; StepEn = 1'b0; Sw8 = 1'b0;
    #1;
    check_eq("rst_pc", Pc, 0);
    check_eq("rst_phase", Phase, 0);
    check_eq("rst_flags", {AccWE, RegWE, Waiting, Stepping}, 0);
    reset_dut();
    for (int c = 0; c < 100; c++) begin
      @(negedge Clock);
      if (c < 12) begin
        check_eq("seq_phase", Phase, c % 4);
        check_eq("seq_accwe", AccWE, (c % 4 == 3) ? 1 : 0);
        check_eq("seq_regwe", RegWE, 0);
        check_eq("seq_pc", Pc, c / 4);
      end
      if (c == 95) check_eq("wrap_pc_last", Pc, PROG_LEN - 1);
      if (c == 96) check_eq("wrap_pc_zero", Pc, 0);
      if (c == 99) check_eq("wb25_accwe", {Phase, AccWE}, {2'd3, 1'b1});
    end

    // ATR writes the register file only
    for (int k = 0; k < 2; k++) begin
      run_instr(OP_ATR, 1'b0, p, acc_n, reg_n, wait_n);
      check_eq("atr_regwe_pulses", reg_n, 1);
      check_eq("atr_accwe_pulses", acc_n, 0);
    end

    // HEI whose condition is already released passes straight through
    Sw8 = 1'b0;
    run_instr(OP_HEI, 1'b1, p_hei, acc_n, reg_n, wait_n);
    check_eq("hei_pass_enables", acc_n + reg_n, 0);
    check_eq("hei_pass_waiting", wait_n, 0);

    // HEI hold with glitch rejection and debounce latency
    run_instr(OP_HEI, 1'b0, hold, acc_n, reg_n, wait_n);
    check_eq("hei_pass_pc_adv", hold, pc_inc(p_hei));
    check_eq("hei_hold_enables", acc_n + reg_n, 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      if (Waiting && Pc == hold && Phase == 2'd3 && !AccWE && !RegWE) cnt++;
    end
    check_eq("hei_hold_frozen", cnt, 5);
    Sw8 = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Sw8 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      cnt += Waiting;
    end
    check_eq("hei_glitch_ignored", cnt, 10);
    Sw8 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 2 + DEBOUNCE; i++) begin
      @(negedge Clock);
      cnt += Waiting;
    end
    check_eq("hei_latency_still_wait", cnt, 2 + DEBOUNCE);
    @(negedge Clock);
    check_eq("hei_release_waiting", Waiting, 0);
    check_eq("hei_release_pc", Pc, pc_inc(hold));
    check_eq("hei_release_phase", Phase, 0);

    // Single-step mode
    Func = OP_ADD; StepEn = 1'b1; Sw8 = 1'b0; StepReq = 1'b0;
    reset_dut();
    for (int c = 0; c < 4; c++) @(negedge Clock);
    check_eq("step_first_wb", {AccWE, Stepping}, 2'b10);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Stepping && Pc == 0) cnt++;
    end
    check_eq("step_hold_50", cnt, 50);
    StepReq = 1'b1;
    @(negedge Clock);
    StepReq = 1'b0;
    check_eq("step_pulse_pc", Pc, 1);
    check_eq("step_pulse_phase", Phase, 0);
    check_eq("step_pulse_stepping", Stepping, 0);
    for (int i = 0; i < 4; i++) @(negedge Clock);
    check_eq("step_back_waiting", {Stepping, 3'(Pc)}, {1'b1, 3'd1});
    StepReq = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge Clock);
    check_eq("step_held_once_pc", Pc, 2);
    check_eq("step_held_once_stepping", Stepping, 1);
    StepEn = 1'b0;
    @(negedge Clock);
    check_eq("step_disable_release", {Stepping, Phase}, 0);
    check_eq("step_disable_pc", Pc, 3);
    StepReq = 1'b0;

    // Asynchronous reset in the middle of an HEI hold at Pc=9
    Func = OP_ADD; StepEn = 1'b0; Sw8 = 1'b1;
    reset_dut();
    for (int c = 0; c < 36; c++) @(negedge Clock);
    run_instr(OP_HEI, 1'b1, p, acc_n, reg_n, wait_n);
    check_eq("rst9_pc", p, 9);
    @(negedge Clock);
    check_eq("rst9_waiting", {Waiting, 3'(Pc >> 2)}, {1'b1, 3'd2});
    @(posedge Clock);
    #3 nReset = 1'b0;
    #1;
    check_eq("async_rst_pc", Pc, 0);
    check_eq("async_rst_outputs", {Phase, AccWE, RegWE, Waiting, Stepping}, 0);
    Sw8 = 1'b0; Func = OP_HEI; HeiArg = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #2 nReset = 1'b1;
    for (int c = 0; c < 5; c++) @(negedge Clock);
    check_eq("post_rst_db_cleared_wait", Waiting, 1);
    check_eq("post_rst_pc", Pc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
